// File: rtl/alu_wb_pkg.sv
// Shared writeback definitions: widths, R15 index, sequencer states, ALU op encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_wb_pkg;

    // Datapath geometry shared by the ALU, decode and writeback
    localparam int WB_DATA_W  = 16;
    localparam int WB_RA_W    = 4;
    localparam int WB_R15_IDX = 15;
    localparam int WB_CNT_W   = 8;

    // Writeback sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_LO  = 2'd1,
        WR_R15 = 2'd2,
        EXC    = 2'd3
    } wb_state_t;

    // ALU op-code encodings; decode and writeback must agree on these
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;

    // Ops whose result carries a second half destined for R15
    function automatic logic op_writes_r15(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_writeback.sv
// Sequences ALU results into the single-port regfile; mul/div add an R15 write, overflow raises an exception.
// Latency: accept N -> low write (or exception pulse) N+1, R15 write N+2.
// Backpressure: wb_ready low while a second cycle (R15 write or exception) is pending; inputs held by producer.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int RA_W    = WB_RA_W,
    parameter int R15_IDX = WB_R15_IDX,
    parameter int CNT_W   = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [RA_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic [DATA_W-1:0] wb_r15,
    input  logic              wb_wr_r15,
    input  logic              wb_ov,
    input  logic [DATA_W-1:0] wb_pc,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_epc,
    output logic [CNT_W-1:0]  ov_count
);

    wb_state_t         state;
    logic [RA_W-1:0]   dest_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] r15_q;
    logic              wr_r15_q;
    logic [DATA_W-1:0] pc_q;
    logic              accept;

    // A new result may land while idle, or while writing a single-write result
    assign wb_ready = (state == IDLE) || ((state == WR_LO) && !wr_r15_q);
    assign accept   = wb_valid && wb_ready;

    // Sequencer state, holding registers and saturating overflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dest_q   <= '0;
            lo_q     <= '0;
            r15_q    <= '0;
            wr_r15_q <= 1'b0;
            pc_q     <= '0;
            ov_count <= '0;
        end else begin
            if (accept) begin
                dest_q   <= wb_dest;
                lo_q     <= wb_lo;
                r15_q    <= wb_r15;
                wr_r15_q <= wb_wr_r15;
                pc_q     <= wb_pc;
                // Overflow wins over any requested R15 write
                state    <= wb_ov ? EXC : WR_LO;
            end else begin
                case (state)
                    WR_LO:   state <= wr_r15_q ? WR_R15 : IDLE;
                    WR_R15:  state <= IDLE;
                    EXC:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if ((state == EXC) && (ov_count != {CNT_W{1'b1}})) begin
                ov_count <= ov_count + CNT_W'(1);
            end
        end
    end

    // Output decode from registered state; unused fields forced to zero
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        exc_valid = 1'b0;
        exc_epc   = '0;
        case (state)
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = lo_q;
            end
            WR_R15: begin
                rf_we    = 1'b1;
                rf_waddr = RA_W'(R15_IDX);
                rf_wdata = r15_q;
            end
            EXC: begin
                exc_valid = 1'b1;
                exc_epc   = pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed stimulus against a cycle-scheduled event model of the writeback rules.
// Latency: model schedules low write/exception at N+1, R15 write at N+2, counter update at N+2.
// Backpressure: model marks cycles where a new result must not be accepted.
module tb_alu_writeback;
    import alu_wb_pkg::*;

    localparam int NC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_dest;
    logic [15:0] wb_lo;
    logic [15:0] wb_r15;
    logic        wb_wr_r15;
    logic        wb_ov;
    logic [15:0] wb_pc;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        exc_valid;
    logic [15:0] exc_epc;
    logic [7:0]  ov_count;

    alu_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dest   (wb_dest),
        .wb_lo     (wb_lo),
        .wb_r15    (wb_r15),
        .wb_wr_r15 (wb_wr_r15),
        .wb_ov     (wb_ov),
        .wb_pc     (wb_pc),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .exc_valid (exc_valid),
        .exc_epc   (exc_epc),
        .ov_count  (ov_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected per-cycle events, indexed by cycle number
    bit m_we   [NC];
    int m_addr [NC];
    int m_data [NC];
    bit m_exc  [NC];
    int m_epc  [NC];
    bit m_busy [NC];
    int ov_q[$];
    int m_ov = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_slot(input int c);
        int i;
        i = c % NC;
        m_we[i] = 1'b0; m_addr[i] = 0; m_data[i] = 0;
        m_exc[i] = 1'b0; m_epc[i] = 0; m_busy[i] = 1'b0;
    endtask

    task automatic check_outputs();
        int i;
        i = cyc % NC;
        while (ov_q.size() > 0 && ov_q[0] <= cyc) begin
            void'(ov_q.pop_front());
            if (m_ov < 255) m_ov++;
        end
        chk("rf_we",     32'(rf_we),     32'(m_we[i]));
        chk("rf_waddr",  32'(rf_waddr),  m_addr[i]);
        chk("rf_wdata",  32'(rf_wdata),  m_data[i]);
        chk("exc_valid", 32'(exc_valid), 32'(m_exc[i]));
        chk("exc_epc",   32'(exc_epc),   m_epc[i]);
        chk("ov_count",  32'(ov_count),  m_ov);
        chk("wb_ready",  32'(wb_ready),  32'(!m_busy[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // One cycle: check, drive, record accepted transfer into the model, advance
    task automatic cycle_step(input bit v, input logic [3:0] d, input logic [15:0] lo,
                              input logic [15:0] r15, input bit wr, input bit ov,
                              input logic [15:0] pc, output bit acc);
        int n1, n2;
        check_outputs();
        wb_valid = v; wb_dest = d; wb_lo = lo; wb_r15 = r15;
        wb_wr_r15 = wr; wb_ov = ov; wb_pc = pc;
        acc = v && !m_busy[cyc % NC];
        n1 = (cyc + 1) % NC;
        n2 = (cyc + 2) % NC;
        if (acc) begin
            if (ov) begin
                m_exc[n1] = 1'b1; m_epc[n1] = int'(pc); m_busy[n1] = 1'b1;
                ov_q.push_back(cyc + 2);
            end else begin
                m_we[n1] = 1'b1; m_addr[n1] = int'(d); m_data[n1] = int'(lo);
                if (wr) begin
                    m_we[n2] = 1'b1; m_addr[n2] = 15; m_data[n2] = int'(r15);
                    m_busy[n1] = 1'b1; m_busy[n2] = 1'b1;
                end
            end
        end
        clear_slot(cyc);
        tick();
    endtask

    task automatic send(input logic [3:0] d, input logic [15:0] lo, input logic [15:0] r15,
                        input bit wr, input bit ov, input logic [15:0] pc, output int waits);
        bit acc;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 8) begin
            cycle_step(1'b1, d, lo, r15, wr, ov, pc, acc);
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", 32'(waits), 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) begin
            cycle_step(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0,
                       16'($urandom), acc);
        end
    endtask

    task automatic do_reset();
        check_outputs();
        rst = 1'b1;
        wb_valid = 1'b0;
        clear_slot(cyc);
        tick();
        for (int k = 0; k < 4; k++) clear_slot(cyc + k);
        ov_q.delete();
        m_ov = 0;
        rst = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        wb_valid = 1'b0; wb_dest = '0; wb_lo = '0; wb_r15 = '0;
        wb_wr_r15 = 1'b0; wb_ov = 1'b0; wb_pc = '0;
        @(negedge clk);
        tick();
        tick();
        for (int k = 0; k < 4; k++) clear_slot(cyc + k);
        rst = 1'b0;
        tick();
        // Reset state
        chk("reset_ready", 32'(wb_ready), 1);
        chk("reset_ovcnt", 32'(ov_count), 0);
        idle(2);

        // ADD: single low write
        send(4'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0010, w);
        chk("add_wdata", 32'(rf_wdata), 32'h1234);
        idle(2);

        // MUL: low write then R15 write
        send(4'd2, 16'h0010, 16'h0001, 1'b1, 1'b0, 16'h0020, w);
        chk("mul_ready_low", 32'(wb_ready), 0);
        idle(3);

        // Overflow with R15 request: exception only
        send(4'd4, 16'h8000, 16'h7777, 1'b1, 1'b1, 16'h0042, w);
        chk("ov_epc", 32'(exc_epc), 32'h0042);
        idle(3);
        chk("ov_count_one", 32'(ov_count), 1);

        // Back-to-back single writes: no stalls expected
        for (int k = 0; k < 4; k++) begin
            send(4'(k + 5), 16'(16'hA000 + k), 16'h0, 1'b0, 1'b0, 16'(k), w);
            chk("b2b_stall", 32'(w), 0);
        end
        idle(2);

        // Dest R15 with R15 write: both in order
        send(4'd15, 16'hBEEF, 16'hCAFE, 1'b1, 1'b0, 16'h0050, w);
        idle(3);

        // Reset during WR_LO of a MUL drops the R15 write
        send(4'd6, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h0060, w);
        do_reset();
        chk("midrst_ovcnt", 32'(ov_count), 0);
        idle(3);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            send(4'($urandom), 16'($urandom), 16'($urandom), ($urandom % 3) == 0,
                 ($urandom % 6) == 0, 16'($urandom), w);
            if (($urandom % 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        // Saturation of the overflow counter
        do_reset();
        for (int n = 0; n < 260; n++) begin
            send(4'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1, 16'($urandom), w);
        end
        idle(3);
        chk("ov_saturate", 32'(ov_count), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback sequencer on the result side of the 16-bit datapath ALU. Accepts one ALU result per handshake and drives the single-write-port register file: the low result goes to the destination register, and for multiply/divide a second cycle writes R15. A signed-overflow exception suppresses all writes and raises a one-cycle exception pulse carrying the faulting PC.

## Interface
Parameters:
- DATA_W, 16, register/result width
- RA_W, 4, register index width
- R15_IDX, 15, index of the implicit high/quotient register
- CNT_W, 8, width of saturating overflow counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- wb_valid  in  1  result presented this cycle
- wb_ready  out  1  block can accept; transfer when wb_valid & wb_ready
- wb_dest  in  RA_W  destination (op1) register index
- wb_lo  in  DATA_W  value for wb_dest
- wb_r15  in  DATA_W  value for R15 (mult high half / div quotient)
- wb_wr_r15  in  1  second write to R15 required
- wb_ov  in  1  overflow exception for this result
- wb_pc  in  DATA_W  PC of the producing instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  RA_W  register-file write index
- rf_wdata  out  DATA_W  register-file write data
- exc_valid  out  1  one-cycle overflow exception pulse
- exc_epc  out  DATA_W  faulting PC, valid with exc_valid
- ov_count  out  CNT_W  overflow exceptions since reset, saturating

## Operation
- States: IDLE, WR_LO, WR_R15, EXC.
- Holding registers capture dest, lo, r15, wr_r15, pc on every accepted transfer.
- wb_ready = (state==IDLE) | (state==WR_LO & !wr_r15_q).
- On accept: wb_ov=1 -> EXC; else -> WR_LO.
- WR_LO: rf_we=1, rf_waddr=dest_q, rf_wdata=lo_q. Next: WR_R15 if wr_r15_q. Otherwise the next state is WR_LO or EXC on a same-cycle accept, else IDLE.
- WR_R15: rf_we=1, rf_waddr=R15_IDX, rf_wdata=r15_q. Next: IDLE.
- EXC: rf_we=0, exc_valid=1, exc_epc=pc_q. ov_count increments, holding at all-ones. Next: IDLE.
- wb_ov together with wb_wr_r15: overflow wins. No register write.
- wb_dest==R15_IDX with wb_wr_r15: both writes issue in order; R15 ends with wb_r15.
- rf_waddr/rf_wdata are 0 whenever rf_we=0. exc_epc is 0 whenever exc_valid=0.

## Timing
- All outputs decode from registered state/holding regs; no input-to-output combinational path except to wb_ready (none: depends on state only).
- Reset: state=IDLE, holding regs=0, ov_count=0. rf_we=0, rf_waddr=0, rf_wdata=0, exc_valid=0, exc_epc=0, wb_ready=1 in the cycle after rst deasserts.
- Latency: accept in cycle N -> low write in N+1. R15 write (if any) in N+2. Exception pulse in N+1.
- Throughput: 1/cycle for single-write results. 2 cycles for R15 results. 2 cycles for exceptions (ready low in EXC).
- rst asserted mid-sequence: pending R15 write or exception is dropped; outputs 0 next cycle.
- wb_valid with wb_ready=0: no capture. The producer holds its inputs stable.

## Structure
- Shared package alu_wb_pkg: state enum (IDLE, WR_LO, WR_R15, EXC), R15_IDX, DATA_W/RA_W constants. The ALU op-code constants (add/sub/mul/div/and/or encodings) are also exported from it so decode and writeback agree.
- Single flat module; no sub-module warranted.

## Test plan
- ADD result: accept dest=3, lo=0x1234, wr_r15=0, ov=0 -> next cycle rf_we=1, waddr=3, wdata=0x1234; then idle with rf_we=0.
- MUL result: accept dest=2, lo=0x0010, r15=0x0001, wr_r15=1 -> cycle+1 write R2=0x0010, cycle+2 write R15=0x0001, wb_ready low in cycle+1.
- Overflow: accept dest=4, lo=0x8000, pc=0x0042, ov=1 -> no rf_we. exc_valid=1, exc_epc=0x0042 for exactly one cycle. ov_count 0->1.
- Back-to-back: four single-write results on consecutive cycles -> four consecutive rf_we cycles, in order, no bubbles.
- Reset mid-op: rst during WR_LO of a MUL -> no R15 write follows. All outputs 0 and ov_count=0 after reset. wb_ready=1.
- Saturation: 260 overflow transfers -> ov_count stops at 0xFF.
